// File: rtl/keypad_pkg.sv
// Shared keypad types, key encodings and the row/column key map.
// Also used by the lock-code entry FSM for the '*' and '#' codes.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} scan_state_t;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1,     4'h2, 4'h3,     4'hA},
        '{4'h4,     4'h5, 4'h6,     4'hB},
        '{4'h7,     4'h8, 4'h9,     4'hC},
        '{KEY_STAR, 4'h0, KEY_HASH, 4'hD}
    };

    // Index of the lowest-numbered active-low row; rows are scanned high to low
    // so the lowest index overwrites and wins.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Resets to RST_VAL so idle (pulled-up) inputs read as inactive.
module sync_2ff #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one column per scan tick, debounced press and
// release, one key_valid strobe per accepted press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int COLS           = 4,
    parameter int ROWS           = 4,
    parameter int DEBOUNCE_TICKS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            scan_tick,
    input  logic [ROWS-1:0] row_in,
    output logic [COLS-1:0] col_out,
    output logic [3:0]      key_code,
    output logic            key_valid,
    output logic            key_held
);

    localparam logic [2:0] DEB_TARGET = 3'(DEBOUNCE_TICKS);

    logic [ROWS-1:0] rows_s;

    sync_2ff #(.WIDTH(ROWS), .RST_VAL('1)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d_i (row_in),
        .q_o (rows_s)
    );

    scan_state_t state_q;
    logic [1:0]  col_idx_q;
    logic [1:0]  row_idx_q;
    logic [2:0]  deb_cnt_q;
    logic [3:0]  col_out_q;
    logic [3:0]  key_code_q;
    logic        key_valid_q;
    logic        key_held_q;

    logic [1:0]  col_next_d;
    logic [2:0]  deb_inc_d;
    logic        row_low_d;
    logic [1:0]  row_sel_d;
    logic [3:0]  key_sel_d;

    // col_idx is frozen outside SCAN, so it doubles as the candidate column.
    always_comb begin
        col_next_d = col_idx_q + 2'd1;
        deb_inc_d  = deb_cnt_q + 3'd1;
        row_low_d  = !rows_s[row_idx_q];
        row_sel_d  = (state_q == SCAN) ? lowest_low(rows_s) : row_idx_q;
        key_sel_d  = KEYMAP[row_sel_d][col_idx_q];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            deb_cnt_q   <= 3'd0;
            col_out_q   <= 4'b1110;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (scan_tick) begin
                case (state_q)
                    SCAN: begin
                        if (rows_s != '1) begin
                            row_idx_q <= row_sel_d;
                            if (DEBOUNCE_TICKS == 1) begin
                                key_code_q  <= key_sel_d;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                deb_cnt_q   <= 3'd0;
                                state_q     <= HELD;
                            end else begin
                                deb_cnt_q <= 3'd1;
                                state_q   <= DEBOUNCE;
                            end
                        end else begin
                            col_idx_q <= col_next_d;
                            col_out_q <= col_drive(col_next_d);
                        end
                    end
                    DEBOUNCE: begin
                        if (row_low_d) begin
                            if (deb_inc_d == DEB_TARGET) begin
                                key_code_q  <= key_sel_d;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                deb_cnt_q   <= 3'd0;
                                state_q     <= HELD;
                            end else begin
                                deb_cnt_q <= deb_inc_d;
                            end
                        end else begin
                            deb_cnt_q <= 3'd0;
                            col_idx_q <= col_next_d;
                            col_out_q <= col_drive(col_next_d);
                            state_q   <= SCAN;
                        end
                    end
                    HELD: begin
                        // Only the accepted key's row matters here; no rollover.
                        if (!row_low_d) begin
                            if (deb_inc_d == DEB_TARGET) begin
                                key_held_q <= 1'b0;
                                deb_cnt_q  <= 3'd0;
                                col_idx_q  <= col_next_d;
                                col_out_q  <= col_drive(col_next_d);
                                state_q    <= SCAN;
                            end else begin
                                deb_cnt_q <= deb_inc_d;
                            end
                        end else begin
                            deb_cnt_q <= 3'd0;
                        end
                    end
                    default: state_q <= SCAN;
                endcase
            end
        end
    end

    assign col_out   = col_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule
